mem_request_arbiter: RTL

- Parametrised successor to the single-core request unit.
- Arbitrates NREQ independent memory requesters (I-fetch, D-read/write, extra cores) onto one shared memory port.
- Each channel's read/write enable is held until the memory returns a hit, then the hit is routed back to the owning channel only.
- Sits between the datapath/cache request logic and the memory controller.

---
 rtl/mem_request_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_request_arbiter.sv
// ============================================================================
// Module   : mem_request_arbiter
// Purpose  : Arbitrates NREQ memory requesters onto one shared memory port.
//            Round-robin or fixed-priority grant; the grant, address and write
//            data are registered and held until mem_hit, and the hit is routed
//            back to the owning channel only.
// Options  : define REQ_WATCHDOG_EN to enable the transaction watchdog (err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_request_arbiter #(
  parameter int NREQ    = 2,
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req_ren,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_hit,
  output logic [DWIDTH-1:0]        req_rdata,
  output logic                     mem_ren,
  output logic                     mem_wen,
  output logic [AWIDTH-1:0]        mem_addr,
  output logic [DWIDTH-1:0]        mem_wdata,
  input  logic                     mem_hit,
  input  logic [DWIDTH-1:0]        mem_rdata,
  output logic                     busy,
  output logic                     err
);

  localparam int C_GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [C_GW-1:0]     r_grant;
  logic [C_GW-1:0]     r_ptr;
  logic                r_mem_ren;
  logic                r_mem_wen;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdata;
  logic                r_err;

  logic [NREQ-1:0]     w_req;
  logic                w_any;
  logic [C_GW-1:0]     w_win;
  logic                w_owner;
  logic                w_load;
  logic                w_clear;
  logic                w_expire;
  logic                w_cnt_done;

  assign w_req = req_ren | req_wen;
  assign w_any = |w_req;

  // Winner selection: scan candidates in descending preference so the most
  // preferred requester is the last (and therefore final) assignment.
  always_comb begin
    int idx;
    w_win = '0;
    idx   = 0;
    if (RR_MODE != 0) begin
      for (int k = NREQ; k >= 1; k--) begin
        idx = (int'(r_ptr) + k) % NREQ;
        if (w_req[idx]) w_win = C_GW'(idx);
      end
    end else begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (w_req[i]) w_win = C_GW'(i);
      end
    end
  end

  assign w_owner = w_req[r_grant];

`ifdef REQ_WATCHDOG_EN
  localparam int             C_CW    = $clog2(TIMEOUT + 1);
  localparam logic [C_CW-1:0] C_TO_M1 = C_CW'(TIMEOUT - 1);

  logic [C_CW-1:0] r_wd_cnt;

  // Expiry fires on the edge where the count would reach TIMEOUT.
  assign w_cnt_done = (r_wd_cnt == C_TO_M1) && !mem_hit;

  // Watchdog count: restart on entry to BUSY/DRAIN, advance while waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wd_cnt <= '0;
    end else if ((w_next != r_state) && (w_next != S_IDLE)) begin
      r_wd_cnt <= '0;
    end else if ((r_state != S_IDLE) && !mem_hit) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_err <= 1'b0;
    else if (w_expire) r_err <= 1'b1;
  end
`else
  assign w_cnt_done = 1'b0;
  assign r_err      = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic plus load/clear strobes for the memory-side registers.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_clear  = 1'b0;
    w_expire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_load = 1'b1;
          w_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_hit) begin
          w_clear = 1'b1;
          w_next  = S_IDLE;
        end else if (w_cnt_done) begin
          w_clear  = 1'b1;
          w_expire = 1'b1;
          w_next   = S_IDLE;
        end else if (!w_owner) begin
          // The memory cannot abort, so keep driving it and swallow the hit.
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_hit) begin
          w_clear = 1'b1;
          w_next  = S_IDLE;
        end else if (w_cnt_done) begin
          w_clear  = 1'b1;
          w_expire = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: begin
        w_clear = 1'b1;
        w_next  = S_IDLE;
      end
    endcase
  end

  // Memory-side registers: capture the winner's request, hold until done.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_grant   <= '0;
      r_ptr     <= C_GW'(NREQ - 1);
      r_mem_ren <= 1'b0;
      r_mem_wen <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (w_load) begin
      r_grant   <= w_win;
      r_ptr     <= w_win;
      r_mem_wen <= req_wen[w_win];
      r_mem_ren <= req_ren[w_win] & ~req_wen[w_win];
      r_addr    <= req_addr[int'(w_win)*AWIDTH +: AWIDTH];
      r_wdata   <= req_wdata[int'(w_win)*DWIDTH +: DWIDTH];
    end else if (w_clear) begin
      r_mem_ren <= 1'b0;
      r_mem_wen <= 1'b0;
    end
  end

  // Hit routing: only the owner sees the hit, and only while not draining.
  always_comb begin
    req_hit = '0;
    if ((r_state == S_BUSY) && mem_hit) req_hit[r_grant] = 1'b1;
  end

  assign req_rdata = mem_rdata;
  assign mem_ren   = r_mem_ren;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

endmodule

`default_nettype wire
